// File: rtl/pad_attr_ctrl.sv
// Per-pad attribute register bank for the DIO pad ring: WARL-masked storage,
// per-pad write lock, default sweep after reset, single-beat read/write port.

module pad_attr_cell #(
  parameter int AttrDw = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              i_we,
  input  logic              i_lock,
  input  logic [AttrDw-1:0] i_wdata,
  output logic [AttrDw-1:0] o_attr,
  output logic              o_lock
);
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      o_attr <= '0;
      o_lock <= 1'b0;
    end else if (i_we) begin
      o_attr <= i_wdata;
      o_lock <= i_lock;
    end
  end
endmodule

module pad_attr_ctrl #(
  parameter int                NDioPads    = 24,
  parameter int                AttrDw      = 32,
  parameter int                PadIdxW     = 5,
  parameter logic [AttrDw-1:0] DefaultAttr = '0
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [AttrDw-1:0]          warl_mask_i,
  input  logic                       req_valid_i,
  output logic                       req_ready_o,
  input  logic                       req_we_i,
  input  logic                       req_lock_i,
  input  logic [PadIdxW-1:0]         req_idx_i,
  input  logic [AttrDw-1:0]          req_wdata_i,
  output logic                       rsp_valid_o,
  output logic [AttrDw-1:0]          rsp_rdata_o,
  output logic                       rsp_err_o,
  output logic                       init_done_o,
  output logic [NDioPads*AttrDw-1:0] pad_attr_o
);
  typedef enum logic {ST_INIT, ST_IDLE} state_e;

  state_e                           r_state;
  logic [PadIdxW-1:0]               r_cnt;
  logic [NDioPads-1:0][AttrDw-1:0]  w_attr;
  logic [NDioPads-1:0]              w_lock;
  logic [NDioPads-1:0]              w_we;
  logic [AttrDw-1:0]                w_wdata;
  logic                             w_lock_in;
  logic                             w_accept;
  logic                             w_in_range;
  logic [AttrDw-1:0]                w_cur;
  logic                             w_cur_lock;
  logic                             w_wr_ok;
  logic [AttrDw-1:0]                w_masked;

  assign w_accept   = req_valid_i & req_ready_o;
  assign w_in_range = (32'(req_idx_i) < NDioPads);
  assign w_cur      = w_in_range ? w_attr[req_idx_i] : '0;
  assign w_cur_lock = w_in_range ? w_lock[req_idx_i] : 1'b0;
  assign w_wr_ok    = w_accept & req_we_i & w_in_range & ~w_cur_lock;
  assign w_masked   = req_wdata_i & warl_mask_i;

  // One shared write bus; the sweep and the request port never overlap in time.
  assign w_wdata   = (r_state == ST_INIT) ? (DefaultAttr & warl_mask_i) : w_masked;
  assign w_lock_in = (r_state == ST_INIT) ? 1'b0 : req_lock_i;

  always_comb begin
    w_we = '0;
    for (int p = 0; p < NDioPads; p++)
      w_we[p] = ((r_state == ST_INIT) && (r_cnt == PadIdxW'(p))) ||
                (w_wr_ok && (req_idx_i == PadIdxW'(p)));
  end

  for (genvar p = 0; p < NDioPads; p++) begin : g_pad
    pad_attr_cell #(.AttrDw(AttrDw)) u_cell (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .i_we   (w_we[p]),
      .i_lock (w_lock_in),
      .i_wdata(w_wdata),
      .o_attr (w_attr[p]),
      .o_lock (w_lock[p])
    );
  end

  assign pad_attr_o = w_attr;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= ST_INIT;
      r_cnt       <= '0;
      req_ready_o <= 1'b0;
      init_done_o <= 1'b0;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
    end else begin
      case (r_state)
        ST_INIT: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == PadIdxW'(NDioPads - 1)) begin
            r_state     <= ST_IDLE;
            req_ready_o <= 1'b1;
            init_done_o <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      rsp_valid_o <= w_accept;
      // Response data/err hold between pulses.
      if (w_accept) begin
        if (!w_in_range) begin
          rsp_rdata_o <= '0;
          rsp_err_o   <= 1'b1;
        end else if (req_we_i && !w_cur_lock) begin
          rsp_rdata_o <= w_masked;
          rsp_err_o   <= 1'b0;
        end else begin
          rsp_rdata_o <= w_cur;
          rsp_err_o   <= req_we_i;
        end
      end
    end
  end
endmodule
